// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave: fill byte, mode encodings
// ({cpol,cpha}) and the transfer state enum.
package spi_pkg;

    localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/spislave_sync_edge.sv
// Multi-stage synchronizer for one asynchronous bit, with rise/fall pulses
// derived from the last two synchronized samples.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // NOTE: clocked state uses non-blocking assignments so every stage
    // samples the value from before the edge, keeping the chain a true shift.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spislave.sv
// SPI slave: oversamples sclk/mosi/cs on clkin and shifts one byte per
// transfer, MSB first, full duplex, with host rx/tx registers and flags.
module spislave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = SPI_FILL_BYTE
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       cspol,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] data_i,
    input  logic       load,
    output logic       tx_empty,
    output logic [7:0] data_o,
    output logic       rx_valid,
    output logic       rx_full,
    input  logic       rd,
    output logic       overrun,
    output logic       underrun,
    input  logic       clr,
    output logic       busy
);

    logic                   sclk_q, sclk_rise, sclk_fall;
    logic                   cs_q, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;

    state_t     state;
    logic [7:0] shift;
    logic [7:0] hold;
    logic [2:0] cnt;
    logic [7:0] start_byte;
    logic       start_fill;

    logic cs_act, act_rise;
    logic sclk_edge, leading, trailing, sample, present;
    logic complete, do_start;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clkin (clkin),
        .rst   (rst),
        .d     (sclk),
        .q     (sclk_q),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clkin (clkin),
        .rst   (rst),
        .d     (cs),
        .q     (cs_q),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // mosi only needs the same delay as sclk so samples stay aligned.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // cs activity edges come from the raw cs edges so a cspol change while
    // idle cannot fake a start.
    assign cs_act    = (cs_q == cspol);
    assign act_rise  = cspol ? cs_rise : cs_fall;
    assign sclk_edge = sclk_rise | sclk_fall;
    assign leading   = sclk_edge & (sclk_q != cpol);
    assign trailing  = sclk_edge & (sclk_q == cpol);
    assign sample    = cpha ? trailing : leading;
    assign present   = cpha ? leading  : trailing;
    assign complete  = (state == SHIFT) && cs_act && sample && (cnt == 3'd7);
    assign do_start  = ((state == IDLE) && act_rise) || complete;
    assign busy      = (state == SHIFT);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        start_byte = FILL_BYTE;
        start_fill = 1'b1;
        if (!tx_empty) begin
            start_byte = hold;
            start_fill = 1'b0;
        end else if (load) begin
            start_byte = data_i;
            start_fill = 1'b0;
        end
    end

    // NOTE: hold and shift are plain flops, not a memory array, so they take
    // the asynchronous reset like every other register.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            hold     <= '0;
            cnt      <= '0;
            tx_empty <= 1'b1;
            data_o   <= '0;
            rx_valid <= 1'b0;
            rx_full  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // A load that coincides with a start on an empty register is
            // consumed directly by the shift register.
            if (load && !(do_start && tx_empty)) begin
                hold     <= data_i;
                tx_empty <= 1'b0;
            end else if (do_start) begin
                tx_empty <= 1'b1;
            end

            if (complete)  rx_full <= 1'b1;
            else if (rd)   rx_full <= 1'b0;

            if (complete && rx_full && !rd) overrun <= 1'b1;
            else if (clr)                   overrun <= 1'b0;

            if (do_start && start_fill) underrun <= 1'b1;
            else if (clr)               underrun <= 1'b0;

            case (state)
                IDLE: begin
                    miso_oe <= 1'b0;
                    if (do_start) begin
                        state   <= SHIFT;
                        shift   <= start_byte;
                        cnt     <= '0;
                        miso_oe <= 1'b1;
                        if (!cpha) miso <= start_byte[7];
                    end
                end
                SHIFT: begin
                    if (!cs_act) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        miso_oe <= 1'b0;
                    end else if (sample) begin
                        if (cnt == 3'd7) begin
                            data_o   <= {shift[6:0], mosi_s};
                            rx_valid <= 1'b1;
                            shift    <= start_byte;
                            cnt      <= '0;
                            if (!cpha) miso <= start_byte[7];
                        end else begin
                            shift <= {shift[6:0], mosi_s};
                            cnt   <= cnt + 3'd1;
                        end
                    end else if (present) begin
                        // With cpha=0 the trailing edge right after a byte
                        // start must keep the new MSB already on miso.
                        if (cpha || cnt != 3'd0) miso <= shift[7];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spislave.sv
// Self-checking bench for spislave: a byte-level SPI master plus a
// behavioural model of the host registers and flags.
module tb_spislave;
    import spi_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 80;

    logic       clkin = 1'b0;
    logic       rst, cpol, cpha, cspol, sclk, mosi, cs, load, rd, clr;
    logic [7:0] data_i;
    logic       miso, miso_oe, tx_empty, rx_valid, rx_full, overrun, underrun, busy;
    logic [7:0] data_o;

    always #5 clkin = ~clkin;

    spislave #(.SYNC_STAGES(SYNC), .FILL_BYTE(SPI_FILL_BYTE)) dut (
        .clkin(clkin), .rst(rst), .cpol(cpol), .cpha(cpha), .cspol(cspol),
        .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso), .miso_oe(miso_oe),
        .data_i(data_i), .load(load), .tx_empty(tx_empty), .data_o(data_o),
        .rx_valid(rx_valid), .rx_full(rx_full), .rd(rd), .overrun(overrun),
        .underrun(underrun), .clr(clr), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // rx_valid monitor
    int         rxv_cnt  = 0;
    int         rxv_long = 0;
    logic       rxv_prev = 1'b0;
    time        rxv_time = 0;
    logic [7:0] rx_q[$];

    always @(posedge clkin) begin
        rxv_prev <= rx_valid;
        if (rx_valid) begin
            rxv_cnt  <= rxv_cnt + 1;
            rxv_time <= $time;
            rx_q.push_back(data_o);
            if (rxv_prev) rxv_long <= rxv_long + 1;
        end
    end

    // Behavioural model of the host-side registers
    bit         m_hold_v;
    logic [7:0] m_hold;
    bit         m_full, m_over, m_under;
    logic [7:0] m_data;
    int         m_rxv;
    logic [7:0] exp_mq[$];
    time        t_edge;

    task automatic m_reset();
        m_hold_v = 0; m_hold = '0; m_full = 0; m_over = 0; m_under = 0;
        m_data = '0; exp_mq.delete();
    endtask

    task automatic m_start();
        if (m_hold_v) begin
            exp_mq.push_back(m_hold);
            m_hold_v = 0;
        end else begin
            exp_mq.push_back(SPI_FILL_BYTE);
            m_under = 1;
        end
    endtask

    task automatic m_complete(input logic [7:0] b);
        if (m_full) m_over = 1;
        m_full = 1;
        m_data = b;
        m_rxv++;
    endtask

    task automatic host_load(input logic [7:0] d);
        @(negedge clkin); data_i = d; load = 1'b1;
        @(negedge clkin); load = 1'b0;
        m_hold = d; m_hold_v = 1;
    endtask

    task automatic host_rd();
        @(negedge clkin); rd = 1'b1;
        @(negedge clkin); rd = 1'b0;
        m_full = 0;
    endtask

    task automatic host_clr();
        @(negedge clkin); clr = 1'b1;
        @(negedge clkin); clr = 1'b0;
        m_over = 0; m_under = 0;
    endtask

    task automatic set_mode(input logic [1:0] md, input logic p);
        cpol = md[1]; cpha = md[0]; cspol = p; cs = ~p; sclk = md[1]; mosi = 1'b0;
        #200;
    endtask

    task automatic cs_on();
        cs = cspol;
        exp_mq.delete();
        m_start();
        #HALF;
    endtask

    task automatic cs_off();
        #HALF;
        cs = ~cspol;
        #200;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit do_rd,
                            input bit do_load, input logic [7:0] ld, output logic [7:0] rx);
        logic [7:0] exp;
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i]; #HALF;
                rx[i] = miso; sclk = ~cpol; t_edge = $time; #HALF;
                sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = tx[i]; #HALF;
                rx[i] = miso; sclk = cpol; t_edge = $time; #HALF;
            end
            if (i == 4) begin
                if (do_load) host_load(ld);
                if (do_rd)   host_rd();
            end
        end
        if (nbits == 8) begin
            exp = exp_mq.pop_front();
            check("miso byte", {24'd0, rx}, {24'd0, exp});
            m_complete(tx);
            m_start();
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       pol;
        bit         preload;
        logic [7:0] pre_d;
        bit         mid_load;
        logic [7:0] mid_d;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
        logic       exp_under;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] rxb, b0, b1;
    int         base;

    initial begin
        vecs[0] = '{MODE0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h11, 8'hA5, 8'h3C, 1'b0};
        vecs[1] = '{MODE0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h55, 8'hFF, 1'b1};
        vecs[2] = '{MODE1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 8'hC3, 8'h5A, 1'b1};
        vecs[3] = '{MODE2, 1'b0, 1'b1, 8'hE7, 1'b1, 8'h24, 8'h18, 8'hE7, 1'b0};
        vecs[4] = '{MODE3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h6D, 8'hFF, 1'b1};

        rst = 1'b1; cpol = 0; cpha = 0; cspol = 0; sclk = 0; mosi = 0; cs = 1;
        load = 0; rd = 0; clr = 0; data_i = '0; m_rxv = 0;
        m_reset();
        #23;
        check("reset data_o",   {24'd0, data_o}, 0);
        check("reset miso",     {31'd0, miso}, 0);
        check("reset miso_oe",  {31'd0, miso_oe}, 0);
        check("reset rx_valid", {31'd0, rx_valid}, 0);
        check("reset rx_full",  {31'd0, rx_full}, 0);
        check("reset overrun",  {31'd0, overrun}, 0);
        check("reset underrun", {31'd0, underrun}, 0);
        check("reset tx_empty", {31'd0, tx_empty}, 1);
        check("reset busy",     {31'd0, busy}, 0);
        @(negedge clkin); rst = 1'b0;
        #100;

        // Table-driven single-byte frames
        foreach (vecs[n]) begin
            set_mode(vecs[n].mode, vecs[n].pol);
            host_rd(); host_clr();
            base = rxv_cnt;
            if (vecs[n].preload) host_load(vecs[n].pre_d);
            cs_on();
            spi_byte(vecs[n].mosi_b, 8, 1'b0, vecs[n].mid_load, vecs[n].mid_d, rxb);
            cs_off();
            check("vec miso",       {24'd0, rxb}, {24'd0, vecs[n].exp_miso});
            check("vec data_o",     {24'd0, data_o}, {24'd0, vecs[n].mosi_b});
            check("vec rx_valid count", rxv_cnt - base, 1);
            check("vec rx_full",    {31'd0, rx_full}, 1);
            check("vec tx_empty",   {31'd0, tx_empty}, 1);
            check("vec underrun",   {31'd0, underrun}, {31'd0, vecs[n].exp_under});
            check("vec latency",    32'(int'((rxv_time - t_edge - 5) / 10)), SYNC + 1);
            check("vec miso_oe idle", {31'd0, miso_oe}, 0);
            check("vec busy idle",  {31'd0, busy}, 0);
            host_clr();
            check("vec underrun after clr", {31'd0, underrun}, 0);
        end

        // Mode 3, two bytes in one frame, no rd in between
        set_mode(MODE3, 1'b0);
        host_rd(); host_clr(); rx_q.delete();
        host_load(8'h81);
        cs_on();
        check("frame busy",     {31'd0, busy}, 1);
        check("frame miso_oe",  {31'd0, miso_oe}, 1);
        check("frame tx_empty after start", {31'd0, tx_empty}, 1);
        host_load(8'h7E);
        check("frame tx_empty after load", {31'd0, tx_empty}, 0);
        spi_byte(8'h12, 8, 1'b0, 1'b0, 8'h00, b0);
        spi_byte(8'h34, 8, 1'b0, 1'b0, 8'h00, b1);
        cs_off();
        check("frame miso b0", {24'd0, b0}, 32'h81);
        check("frame miso b1", {24'd0, b1}, 32'h7E);
        check("frame rx count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("frame rx b0", {24'd0, rx_q[0]}, 32'h12);
            check("frame rx b1", {24'd0, rx_q[1]}, 32'h34);
        end
        check("frame overrun", {31'd0, overrun}, 1);

        // Same frame with rd during the second byte: no overrun
        host_rd(); host_clr();
        host_load(8'h81);
        cs_on();
        host_load(8'h7E);
        spi_byte(8'h12, 8, 1'b0, 1'b0, 8'h00, b0);
        spi_byte(8'h34, 8, 1'b1, 1'b0, 8'h00, b1);
        cs_off();
        check("frame rd overrun", {31'd0, overrun}, 0);
        check("frame rd data_o",  {24'd0, data_o}, 32'h34);

        // Abort after 5 bits; a load during the aborted byte must survive
        set_mode(MODE0, 1'b0);
        host_rd(); host_clr();
        base = rxv_cnt;
        host_load(8'h22);
        cs_on();
        spi_byte(8'hF0, 5, 1'b0, 1'b1, 8'h44, rxb);
        cs_off();
        check("abort rx_valid",  rxv_cnt - base, 0);
        check("abort data_o",    {24'd0, data_o}, {24'd0, m_data});
        check("abort miso_oe",   {31'd0, miso_oe}, 0);
        check("abort busy",      {31'd0, busy}, 0);
        check("abort tx_empty",  {31'd0, tx_empty}, 0);
        cs_on();
        spi_byte(8'h0F, 8, 1'b0, 1'b0, 8'h00, rxb);
        cs_off();
        check("after abort miso", {24'd0, rxb}, 32'h44);
        check("after abort data", {24'd0, data_o}, 32'h0F);

        // cspol=1: sclk activity with cs low does nothing
        set_mode(MODE1, 1'b1);
        base = rxv_cnt;
        for (int i = 0; i < 8; i++) begin
            sclk = ~cpol; mosi = 1'(i); #HALF;
            sclk = cpol; #HALF;
        end
        #200;
        check("cs inactive rx_valid", rxv_cnt - base, 0);
        check("cs inactive busy",     {31'd0, busy}, 0);
        check("cs inactive miso_oe",  {31'd0, miso_oe}, 0);
        check("cs inactive underrun", {31'd0, underrun}, {31'd0, m_under});

        // Load in the very cycle of the byte start on an empty register
        set_mode(MODE0, 1'b0);
        host_rd(); host_clr();
        check("direct tx_empty before", {31'd0, tx_empty}, {31'd0, !m_hold_v});
        cs = cspol;
        #(10 * SYNC);
        data_i = 8'hA7; load = 1'b1;
        #10;
        load = 1'b0;
        exp_mq.delete(); exp_mq.push_back(8'hA7);
        #(HALF - 10 * SYNC - 10);
        check("direct underrun", {31'd0, underrun}, 0);
        check("direct tx_empty", {31'd0, tx_empty}, 1);
        spi_byte(8'h3B, 8, 1'b0, 1'b0, 8'h00, rxb);
        cs_off();
        check("direct data_o", {24'd0, data_o}, 32'h3B);

        // Reset after 3 bits
        set_mode(MODE0, 1'b0);
        host_load(8'h33);
        cs_on();
        spi_byte(8'hAA, 3, 1'b0, 1'b0, 8'h00, rxb);
        rst = 1'b1;
        #2;
        check("midrst data_o",   {24'd0, data_o}, 0);
        check("midrst miso",     {31'd0, miso}, 0);
        check("midrst miso_oe",  {31'd0, miso_oe}, 0);
        check("midrst rx_full",  {31'd0, rx_full}, 0);
        check("midrst overrun",  {31'd0, overrun}, 0);
        check("midrst underrun", {31'd0, underrun}, 0);
        check("midrst tx_empty", {31'd0, tx_empty}, 1);
        check("midrst busy",     {31'd0, busy}, 0);
        cs = ~cspol; sclk = cpol;
        #98;
        rst = 1'b0;
        m_reset();
        #100;
        host_load(8'h66);
        cs_on();
        spi_byte(8'h99, 8, 1'b0, 1'b0, 8'h00, rxb);
        cs_off();
        check("post rst miso", {24'd0, rxb}, 32'h66);
        check("post rst data", {24'd0, data_o}, 32'h99);

        // Randomized frames against the model
        for (int f = 0; f < 16; f++) begin
            logic [1:0] md;
            logic       pol;
            int         nb;
            md  = 2'($urandom_range(0, 3));
            pol = 1'($urandom_range(0, 1));
            nb  = $urandom_range(1, 3);
            set_mode(md, pol);
            if ($urandom_range(0, 1) == 1) host_rd();
            if ($urandom_range(0, 2) == 0) host_clr();
            if ($urandom_range(0, 1) == 1) host_load(8'($urandom));
            cs_on();
            for (int k = 0; k < nb; k++)
                spi_byte(8'($urandom), 8, 1'($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 1)), 8'($urandom), rxb);
            cs_off();
            check("rand data_o",   {24'd0, data_o}, {24'd0, m_data});
            check("rand rx_full",  {31'd0, rx_full}, {31'd0, m_full});
            check("rand overrun",  {31'd0, overrun}, {31'd0, m_over});
            check("rand underrun", {31'd0, underrun}, {31'd0, m_under});
            check("rand tx_empty", {31'd0, tx_empty}, {31'd0, !m_hold_v});
            check("rand rx count", rxv_cnt, m_rxv);
            check("rand busy",     {31'd0, busy}, 0);
        end

        check("rx_valid single cycle", rxv_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spislave.md
Name: spislave

Overview:
- SPI slave (target) for the Bus Pirate Ultra FPGA; the other end of the SPI master.
- Lets the board emulate an SPI peripheral, or loop back against the master, for self-test.
- Oversamples sclk/mosi/cs with clkin, shifts one byte per transfer, MSB first, full duplex.
- Host side: rx byte register with full/overrun flags; tx holding register with empty/underrun flags.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on sclk/mosi/cs before edge detection (legal range 2..3).
- FILL_BYTE, 8'hFF, byte shifted out when tx holding register is empty at byte start.

Ports:
- clkin  input  1  system clock; must be at least 4x the sclk frequency.
- rst  input  1  asynchronous, active-high reset.
- cpol  input  1  clock polarity; sclk idle level.
- cpha  input  1  clock phase.
- cspol  input  1  active level of cs.
- sclk  input  1  SPI clock from the master.
- mosi  input  1  master out, slave in.
- cs  input  1  chip select from the master.
- miso  output  1  slave out, master in.
- miso_oe  output  1  miso output enable; high only while cs is active.
- data_i  input  8  tx byte from host.
- load  input  1  strobe: capture data_i into the tx holding register.
- tx_empty  output  1  tx holding register empty.
- data_o  output  8  last received byte.
- rx_valid  output  1  one-clkin pulse when a byte completes.
- rx_full  output  1  data_o holds an unread byte.
- rd  input  1  strobe: host has read data_o; clears rx_full.
- overrun  output  1  sticky; a byte completed while rx_full=1.
- underrun  output  1  sticky; FILL_BYTE was sent because tx was empty.
- clr  input  1  clears overrun and underrun.
- busy  output  1  cs is active (synchronized).

Behaviour:
- Reset values:
  - data_o=0, miso=0, miso_oe=0.
  - rx_valid=0, rx_full=0, overrun=0, underrun=0.
  - tx_empty=1, busy=0.
  - Bit counter=0, state=IDLE.
- Synchronization and edge detection:
  - sclk, mosi and cs each pass through SYNC_STAGES flip-flops.
  - Edges are detected by comparing the last synchronized sample with the previous one.
  - Leading edge: sclk leaves the cpol level. Trailing edge: sclk returns to cpol.
  - cs_act = (synchronized cs == cspol).
- State machine, IDLE:
  - miso_oe=0; sclk edges are ignored.
  - On cs_act rising, go to SHIFT and perform a byte start.
- Byte start:
  - If tx_empty=0: move holding register to the shift register; tx_empty becomes 1.
  - If tx_empty=1 and load is high in the same cycle: data_i goes straight to the shift register; no underrun.
  - Otherwise: load FILL_BYTE and set underrun.
  - Bit counter=0. miso_oe=1.
  - If cpha=0, miso = shift[7] immediately.
- State machine, SHIFT with cpha=0:
  - Leading edge: sample mosi into the shift register LSB and increment the count.
  - Trailing edge: present the next bit on miso.
- State machine, SHIFT with cpha=1:
  - Leading edge: present the next bit on miso.
  - Trailing edge: sample mosi.
- 8th sample completes the byte:
  - data_o is updated and rx_valid pulses one cycle later (the cycle after edge detection).
  - rx_full is set; overrun is set if rx_full was already 1.
  - A new byte start occurs in the same cycle, so back-to-back bytes need no cs toggle.
- cs_act falling in any bit position:
  - Return to IDLE; miso_oe=0.
  - A partial byte is discarded: no rx_valid, no flag change.
  - The shift register contents are lost; the holding register is untouched.
- load:
  - load when tx_empty=0 overwrites the holding register. No error flag.
- rd and byte completion in the same cycle: rx_full stays 1, no overrun.
- clr and a flag set in the same cycle: set wins.
- rst mid-transfer returns everything to reset values immediately.
- Latency from the sclk pin edge to rx_valid: SYNC_STAGES+1 clkin cycles.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_FILL_BYTE (8'hFF).
  - Mode encoding constants: MODE0..MODE3 = {cpol,cpha}.
  - The state enum IDLE/SHIFT.
- One natural sub-module: sync_edge, holding the SYNC_STAGES synchronizer plus rise/fall detect for a single bit. It is instantiated for sclk and cs; mosi uses a plain synchronizer.

Test Plan:
- Mode 0, cspol=0:
  - Preload 0x3C; master sends 0xA5.
  - Expect data_o=0xA5, rx_valid one pulse, master receives 0x3C, tx_empty=1.
- Mode 3, two bytes in one cs frame:
  - Preload 0x81, then load 0x7E after the first byte start; master sends 0x12, 0x34.
  - Expect rx 0x12 then 0x34, master receives 0x81, 0x7E, and overrun=1 unless rd pulses between bytes.
- Underrun: no load; master sends 0x55.
  - Expect master receives 0xFF, underrun=1, data_o=0x55.
  - After clr: underrun=0.
- Abort: cs deasserted after 5 sclk cycles of 0xF0.
  - Expect no rx_valid, data_o unchanged, miso_oe=0, busy=0.
  - The next full byte 0x0F is received correctly.
- cspol=1, mode 1:
  - Master sends 0xC3 with cs high-active.
  - Expect data_o=0xC3; cs low produces no activity.
- Reset mid-byte: rst after 3 bits.
  - Expect all outputs at reset values.
  - The following transfer of 0x99 is received intact.
